mmio_fifo_csr: RTL and testbench
================================

MMIO_FIFO_CSR -- requirements
Module: mmio_fifo_csr

Interface
REQ-001 Parameter DATA_W, default 64, FIFO entry width in bits, 1..64; zero-extended to 64 on read.
REQ-002 Parameter DEPTH, default 16, number of FIFO entries; power of 2, 2..1024.
REQ-003 Parameter BASE_ADDR, default 16'h0020, MMIO address of the first user register.
REQ-004 Parameter AFU_ID, default 128'h0, 128-bit accelerator UUID.
REQ-005 clk  input  1  clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 mmio_wr_valid  input  1  host MMIO write strobe, one cycle per write.
REQ-008 mmio_rd_valid  input  1  host MMIO read strobe, one cycle per read.
REQ-009 mmio_addr  input  16  MMIO address (4-byte units), shared by read and write.
REQ-010 mmio_wdata  input  64  MMIO write data.
REQ-011 mmio_rd_tid  input  9  read transaction ID.
REQ-012 rsp_valid  output  1  read response strobe, registered.
REQ-013 rsp_tid  output  9  TID echoed with the response.
REQ-014 rsp_data  output  64  read response data.

Function
REQ-015 Register map: 0x0000 DFH = {4'b0001, 8'b0, 4'b0, 7'b0, 1'b1, 24'b0, 4'b0, 12'b0}; 0x0002 AFU_ID[63:0]; 0x0004 AFU_ID[127:64]; 0x0006, 0x0008 read 0.
REQ-016 BASE+0 DATA: write pushes mmio_wdata[DATA_W-1:0]; read pops head.
REQ-017 BASE+2 STATUS (read-only): [15:0] count, [16] empty, [17] full, [18] overflow sticky, [19] underflow sticky, rest 0.
REQ-018 BASE+4 CONTROL (write-only, reads 0): bit0=1 flush FIFO, bit1=1 clear both stickies; both bits may be set in one write.
REQ-019 BASE+6 PEEK (read-only): head entry without pop; 0 when empty.
REQ-020 BASE+8 SCRATCH: 64-bit read/write register.
REQ-021 Unmapped address: write ignored; read returns 0 with normal response.
REQ-022 Read latency exactly 1 cycle: rd_valid in cycle N -> rsp_valid=1, rsp_tid=mmio_rd_tid, rsp_data in N+1; rsp_valid=0 in every other cycle; rsp_data/rsp_tid hold last value when rsp_valid=0.
REQ-023 Back-to-back reads in consecutive cycles produce back-to-back responses, no stalls.
REQ-024 FIFO is circular buffer; rd/wr pointers wrap from DEPTH-1 to 0; count width clog2(DEPTH)+1.
REQ-025 Push when full: data dropped, count unchanged, overflow sticky set.
REQ-026 Pop when empty: response data 0, pointers unchanged, underflow sticky set.
REQ-027 Pop of entry returns data in FIFO order; count decrements the cycle after the read strobe.
REQ-028 STATUS read reflects state before any action in the same cycle.
REQ-029 mmio_wr_valid and mmio_rd_valid in the same cycle: write performed, read discarded, no response generated.
REQ-030 Flush: pointers and count to 0 next cycle; stored data not cleared; stickies unaffected unless bit1 also set.
REQ-031 Sticky set and clear in the same cycle: set wins.

Reset
REQ-032 On rst: rsp_valid=0, rsp_tid=0, rsp_data=0, FIFO empty (count 0), stickies 0, SCRATCH 0, pointers 0.
REQ-033 rst asserted mid-operation: pending response in flight dropped; rsp_valid stays 0 until first read after deassert.

Verification
REQ-034 Read 0x0000 tid=5 -> next cycle rsp_valid=1, rsp_tid=5, rsp_data=64'h1000_0100_0000_0000.
REQ-035 DEPTH=4: push 1,2,3,4,5 -> STATUS count=4, full=1, overflow=1; pop x5 -> 1,2,3,4,0, underflow=1, empty=1.
REQ-036 Wrap: DEPTH=4, push 3 / pop 3 / push 4 entries A..D -> pops return A,B,C,D in order, count returns to 0.
REQ-037 Push 0xAA, read PEEK twice -> 0xAA both times, count stays 1; write CONTROL=3 -> count=0, stickies=0.
REQ-038 Same-cycle write SCRATCH=0x55 and read -> no rsp_valid; subsequent SCRATCH read returns 0x55.
REQ-039 Assert rst one cycle after a read strobe -> rsp_valid never pulses; STATUS after reset reads 0x0001_0000.

Source files
------------

// File: rtl/mmio_fifo_csr.sv
// mmio_fifo_csr: host-visible CSR block fronting a circular FIFO.
//
// Register map (mmio_addr in 4-byte units):
//   0x0000 DFH, 0x0002 AFU_ID[63:0], 0x0004 AFU_ID[127:64], 0x0006/0x0008 read 0
//   BASE+0 DATA     write pushes, read pops head (0 and underflow when empty)
//   BASE+2 STATUS   [15:0] count, [16] empty, [17] full, [18] overflow, [19] underflow
//   BASE+4 CONTROL  bit0 flush, bit1 clear stickies (write-only, reads 0)
//   BASE+6 PEEK     head entry without pop, 0 when empty
//   BASE+8 SCRATCH  64-bit read/write
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   mmio_wr_valid      one-cycle write strobe
//   mmio_rd_valid      one-cycle read strobe (ignored if a write occurs in the same cycle)
//   mmio_addr          shared read/write address
//   mmio_wdata         write data
//   mmio_rd_tid        read transaction ID, echoed on rsp_tid
//   rsp_valid          read response strobe, exactly one cycle after the read strobe
//   rsp_tid, rsp_data  response TID and data; hold their value between responses
module mmio_fifo_csr #(
  parameter int unsigned   DATA_W    = 64,
  parameter int unsigned   DEPTH     = 16,
  parameter logic [15:0]   BASE_ADDR = 16'h0020,
  parameter logic [127:0]  AFU_ID    = 128'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mmio_wr_valid,
  input  logic        mmio_rd_valid,
  input  logic [15:0] mmio_addr,
  input  logic [63:0] mmio_wdata,
  input  logic [8:0]  mmio_rd_tid,
  output logic        rsp_valid,
  output logic [8:0]  rsp_tid,
  output logic [63:0] rsp_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [CW-1:0] DepthCount = CW'(DEPTH);

  localparam logic [63:0] DfhValue = {4'b0001, 8'b0, 4'b0, 7'b0, 1'b1, 24'b0, 4'b0, 12'b0};

  localparam logic [15:0] AddrDfh     = 16'h0000;
  localparam logic [15:0] AddrIdLo    = 16'h0002;
  localparam logic [15:0] AddrIdHi    = 16'h0004;
  localparam logic [15:0] AddrData    = BASE_ADDR;
  localparam logic [15:0] AddrStatus  = BASE_ADDR + 16'd2;
  localparam logic [15:0] AddrControl = BASE_ADDR + 16'd4;
  localparam logic [15:0] AddrPeek    = BASE_ADDR + 16'd6;
  localparam logic [15:0] AddrScratch = BASE_ADDR + 16'd8;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [63:0]   scratch_q, scratch_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [8:0]    rsp_tid_q, rsp_tid_d;
  logic [63:0]   rsp_data_q, rsp_data_d;

  logic          wr_en, rd_en, push_en;
  logic          empty, full;
  logic [63:0]   head_ext;
  logic [63:0]   status_word;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    scratch_d   = scratch_q;
    rsp_valid_d = 1'b0;
    rsp_tid_d   = rsp_tid_q;
    rsp_data_d  = rsp_data_q;
    push_en     = 1'b0;

    empty = (count_q == '0);
    full  = (count_q == DepthCount);

    // A write in the same cycle as a read wins; the read is dropped entirely.
    wr_en = mmio_wr_valid;
    rd_en = mmio_rd_valid & ~mmio_wr_valid;

    head_ext = '0;
    if (!empty) begin
      head_ext[DATA_W-1:0] = mem[rd_ptr_q];
    end

    // Built from registered state only, so a STATUS read sees the pre-action view.
    status_word         = '0;
    status_word[CW-1:0] = count_q;
    status_word[16]     = empty;
    status_word[17]     = full;
    status_word[18]     = ovf_q;
    status_word[19]     = unf_q;

    if (wr_en) begin
      case (mmio_addr)
        AddrData: begin
          if (full) begin
            ovf_d = 1'b1;
          end else begin
            push_en  = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            count_d  = count_q + CW'(1);
          end
        end
        AddrControl: begin
          if (mmio_wdata[0]) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
          end
          if (mmio_wdata[1]) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
          end
        end
        AddrScratch: scratch_d = mmio_wdata;
        default: ;
      endcase
    end

    if (rd_en) begin
      rsp_valid_d = 1'b1;
      rsp_tid_d   = mmio_rd_tid;
      case (mmio_addr)
        AddrDfh:     rsp_data_d = DfhValue;
        AddrIdLo:    rsp_data_d = AFU_ID[63:0];
        AddrIdHi:    rsp_data_d = AFU_ID[127:64];
        AddrData: begin
          rsp_data_d = head_ext;
          if (empty) begin
            unf_d = 1'b1;
          end else begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            count_d  = count_q - CW'(1);
          end
        end
        AddrStatus:  rsp_data_d = status_word;
        AddrPeek:    rsp_data_d = head_ext;
        AddrScratch: rsp_data_d = scratch_q;
        default:     rsp_data_d = '0;
      endcase
    end
  end

  // Storage is intentionally not reset or cleared on flush.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr_q] <= mmio_wdata[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      scratch_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_tid_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      scratch_q   <= scratch_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_tid_q   <= rsp_tid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_tid   = rsp_tid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mmio_fifo_csr.sv
// Scoreboard bench for mmio_fifo_csr (DEPTH=4). Reads push the expected response onto a
// queue; a negedge monitor pops and compares every response, and flags unexpected or late ones.
module tb_mmio_fifo_csr;

  localparam logic [127:0] Id = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  localparam logic [15:0]  Base = 16'h0020;
  localparam logic [15:0]  RData = Base, RStat = Base + 16'd2, RCtrl = Base + 16'd4;
  localparam logic [15:0]  RPeek = Base + 16'd6, RScr = Base + 16'd8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mmio_wr_valid = 1'b0;
  logic        mmio_rd_valid = 1'b0;
  logic [15:0] mmio_addr = '0;
  logic [63:0] mmio_wdata = '0;
  logic [8:0]  mmio_rd_tid = '0;
  logic        rsp_valid;
  logic [8:0]  rsp_tid;
  logic [63:0] rsp_data;

  mmio_fifo_csr #(
    .DATA_W(64),
    .DEPTH(4),
    .BASE_ADDR(Base),
    .AFU_ID(Id)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mmio_wr_valid(mmio_wr_valid),
    .mmio_rd_valid(mmio_rd_valid),
    .mmio_addr(mmio_addr),
    .mmio_wdata(mmio_wdata),
    .mmio_rd_tid(mmio_rd_tid),
    .rsp_valid(rsp_valid),
    .rsp_tid(rsp_tid),
    .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  tid;
    logic [63:0] data;
    int          due;
    string       name;
  } exp_t;

  exp_t       exp_q[$];
  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic [8:0] tid_ctr = 9'd5;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every response must match the oldest expectation and arrive on its due cycle.
  always @(negedge clk) begin
    if (rsp_valid) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_rsp: got tid=%0d data=%h, required no response",
                 rsp_tid, rsp_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (rsp_tid !== e.tid || rsp_data !== e.data || cyc != e.due) begin
          n_fail++;
          $display("FAIL %s: got tid=%0d data=%h cyc=%0d, required tid=%0d data=%h cyc=%0d",
                   e.name, rsp_tid, rsp_data, cyc, e.tid, e.data, e.due);
        end
      end
    end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s: got no response by cyc=%0d, required tid=%0d data=%h",
               e.name, cyc, e.tid, e.data);
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic do_write(input logic [15:0] a, input logic [63:0] d);
    mmio_wr_valid = 1'b1;
    mmio_addr     = a;
    mmio_wdata    = d;
    @(posedge clk);
    #1;
    mmio_wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] a, input logic [63:0] req, input string name);
    exp_t e;
    e.tid  = tid_ctr;
    e.data = req;
    e.due  = cyc + 1;
    e.name = name;
    exp_q.push_back(e);
    mmio_rd_valid = 1'b1;
    mmio_addr     = a;
    mmio_rd_tid   = tid_ctr;
    @(posedge clk);
    #1;
    mmio_rd_valid = 1'b0;
    tid_ctr       = tid_ctr + 9'd1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_rsp_valid", {63'b0, rsp_valid}, 64'h0);
    check("reset_rsp_tid", {55'b0, rsp_tid}, 64'h0);
    check("reset_rsp_data", rsp_data, 64'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Identity registers and unmapped space, back-to-back; first TID is 5.
    do_read(16'h0000, 64'h1000_0100_0000_0000, "dfh");
    do_read(16'h0002, Id[63:0], "afu_id_lo");
    do_read(16'h0004, Id[127:64], "afu_id_hi");
    do_read(16'h0006, 64'h0, "rsvd_6");
    do_read(16'h0008, 64'h0, "rsvd_8");
    do_read(16'h0100, 64'h0, "unmapped");
    do_read(RCtrl, 64'h0, "control_reads_0");
    do_read(RStat, 64'h0000_0000_0001_0000, "status_empty");

    // Fill past capacity: fifth push overflows.
    for (int i = 1; i <= 5; i++) do_write(RData, 64'(i));
    do_read(RStat, 64'h0000_0000_0006_0004, "status_full_ovf");
    do_read(RData, 64'd1, "pop1");
    do_read(RStat, 64'h0000_0000_0004_0003, "status_after_pop1");
    do_read(RData, 64'd2, "pop2");
    do_read(RData, 64'd3, "pop3");
    do_read(RData, 64'd4, "pop4");
    do_read(RData, 64'd0, "pop_empty");
    do_read(RStat, 64'h0000_0000_000D_0000, "status_empty_ovf_unf");
    do_write(RCtrl, 64'h2);
    do_read(RStat, 64'h0000_0000_0001_0000, "status_cleared");

    // Wrap-around: advance pointers by 3 then run four entries through the boundary.
    do_write(RData, 64'h11);
    do_write(RData, 64'h22);
    do_write(RData, 64'h33);
    do_read(RData, 64'h11, "wrap_pre1");
    do_read(RData, 64'h22, "wrap_pre2");
    do_read(RData, 64'h33, "wrap_pre3");
    do_write(RData, 64'hA);
    do_write(RData, 64'hB);
    do_write(RData, 64'hC);
    do_write(RData, 64'hD);
    do_read(RStat, 64'h0000_0000_0002_0004, "wrap_full");
    do_read(RData, 64'hA, "wrap_a");
    do_read(RData, 64'hB, "wrap_b");
    do_read(RData, 64'hC, "wrap_c");
    do_read(RData, 64'hD, "wrap_d");
    do_read(RStat, 64'h0000_0000_0001_0000, "wrap_empty");

    // Peek, then combined flush + sticky clear.
    do_read(RPeek, 64'h0, "peek_empty");
    do_read(RData, 64'h0, "pop_empty2");
    do_write(RData, 64'hAA);
    do_read(RPeek, 64'hAA, "peek1");
    do_read(RPeek, 64'hAA, "peek2");
    do_read(RStat, 64'h0000_0000_0008_0001, "status_peek_unf");
    do_write(RCtrl, 64'h3);
    do_read(RStat, 64'h0000_0000_0001_0000, "status_flushed");
    do_write(RData, 64'hBB);
    do_read(RPeek, 64'hBB, "peek_after_flush");

    // Simultaneous write and read: write lands, no response.
    mmio_wr_valid = 1'b1;
    mmio_rd_valid = 1'b1;
    mmio_addr     = RScr;
    mmio_wdata    = 64'h55;
    mmio_rd_tid   = 9'h1ff;
    @(posedge clk);
    #1;
    mmio_wr_valid = 1'b0;
    mmio_rd_valid = 1'b0;
    do_read(RScr, 64'h55, "scratch_55");
    do_write(16'h0300, 64'hdead);
    do_read(RScr, 64'h55, "scratch_unmapped_wr");

    // Reset while a response is in flight.
    mmio_rd_valid = 1'b1;
    mmio_addr     = RStat;
    mmio_rd_tid   = 9'h1aa;
    @(posedge clk);
    #1;
    mmio_rd_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_kills_rsp", {63'b0, rsp_valid}, 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rsp_idle_after_rst", {63'b0, rsp_valid}, 64'h0);
    do_read(RStat, 64'h0000_0000_0001_0000, "status_after_rst");
    do_read(RScr, 64'h0, "scratch_after_rst");

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
